// File: rtl/exam_onehot_collector.sv
// rtl/exam_onehot_collector.sv - encodes decoder samples into a FWFT FIFO with a saturating one-hot hit counter
// Optional build macro: EXAM_COLLECT_STRICT_EN (only one-hot samples enter the FIFO)
module exam_onehot_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [2:0]       dout_idx,
    output logic             dout_onehot,
    output logic             dout_zero,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [4:0]  mem [DEPTH];
    logic [4:0]  last_pop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0] level;
    logic        rdy;
    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        pop;
    logic [2:0]  enc_idx;
    logic        enc_onehot;
    logic        enc_zero;
    logic [4:0]  head;

    always_comb begin
        enc_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (din[i]) enc_idx = i[2:0];
        end
    end

    assign enc_zero   = (din == 8'h00);
    assign enc_onehot = !enc_zero && ((din & (din - 8'd1)) == 8'h00);

    assign full       = (level == FULL_LVL);
    assign empty      = (level == '0);
    assign din_ready  = rdy & ~full;
    assign accept     = en & din_valid & din_ready;
    assign dout_valid = ~empty;
    assign pop        = dout_valid & dout_ready;

`ifdef EXAM_COLLECT_STRICT_EN
    assign push = accept & enc_onehot;
`else
    assign push = accept;
`endif

    // Once drained, the outputs keep showing the most recently popped entry.
    assign head = empty ? last_pop : mem[rd_ptr];
    assign dout_idx    = head[4:2];
    assign dout_onehot = head[1];
    assign dout_zero   = head[0];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {enc_idx, enc_onehot, enc_zero};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            last_pop <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            rdy <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                last_pop <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (accept && enc_onehot && (count != '1)) count <= count + 1'b1;
            if (en && din_valid && rdy && full) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_exam_onehot_collector.sv
// tb/tb_exam_onehot_collector.sv - queue-model checking of exam_onehot_collector plus directed literal checks
module tb_exam_onehot_collector;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       dout_ready = 1'b0;
    logic       din_ready, dout_onehot, dout_zero, dout_valid, overflow;
    logic [2:0] dout_idx;
    logic [7:0] count;
    logic       din_ready2, dout_onehot2, dout_zero2, dout_valid2, overflow2;
    logic [2:0] dout_idx2;
    logic [1:0] count2;

    int n_checks = 0;
    int n_err = 0;

    exam_onehot_collector #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout_idx(dout_idx), .dout_onehot(dout_onehot),
        .dout_zero(dout_zero), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .count(count), .overflow(overflow)
    );

    exam_onehot_collector #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(din_ready2), .dout_idx(dout_idx2), .dout_onehot(dout_onehot2),
        .dout_zero(dout_zero2), .dout_valid(dout_valid2), .dout_ready(dout_ready),
        .count(count2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] idx;
        logic       oh;
        logic       z;
    } ent_t;

    ent_t q[$];
    ent_t m_last = '0;
    ent_t m_e;
    ent_t exp_head;
    bit   m_rdy = 1'b0;
    bit   m_ovf = 1'b0;
    bit   m_full, m_acc, m_pop;
    int   m_hits = 0;

    function automatic ent_t encode(logic [7:0] d);
        ent_t e;
        e.z   = (d == 8'h00);
        e.oh  = ($countones(d) == 1);
        e.idx = 3'd0;
        for (int i = 7; i >= 0; i--) if (d[i]) e.idx = 3'(i);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_last = '0;
            m_rdy  = 1'b0;
            m_ovf  = 1'b0;
            m_hits = 0;
        end else begin
            m_full = (q.size() == DEPTH);
            m_acc  = en && din_valid && m_rdy && !m_full;
            m_pop  = (q.size() > 0) && dout_ready;
            m_e    = encode(din);
            if (en && din_valid && m_rdy && m_full) m_ovf = 1'b1;
            if (m_acc && m_e.oh) m_hits++;
            if (m_pop) begin
                m_last = q[0];
                void'(q.pop_front());
            end
`ifdef EXAM_COLLECT_STRICT_EN
            if (m_acc && m_e.oh) q.push_back(m_e);
`else
            if (m_acc) q.push_back(m_e);
`endif
            m_rdy = 1'b1;
        end
    end

    always @(posedge clk) begin
        #2;
        exp_head = (q.size() > 0) ? q[0] : m_last;
        chk("din_ready",   int'(din_ready),   int'(m_rdy && q.size() < DEPTH));
        chk("dout_valid",  int'(dout_valid),  int'(q.size() > 0));
        chk("dout_idx",    int'(dout_idx),    int'(exp_head.idx));
        chk("dout_onehot", int'(dout_onehot), int'(exp_head.oh));
        chk("dout_zero",   int'(dout_zero),   int'(exp_head.z));
        chk("count",       int'(count),       (m_hits > 255) ? 255 : m_hits);
        chk("count_w2",    int'(count2),      (m_hits > 3) ? 3 : m_hits);
        chk("overflow",    int'(overflow),    int'(m_ovf));
    end

    task automatic drive(input logic e, input logic [7:0] d, input logic dv, input logic dr);
        @(negedge clk);
        en = e;
        din = d;
        din_valid = dv;
        dout_ready = dr;
    endtask

    initial begin
        // 1: reset with valid offered
        #1 rst_n = 1'b0;
        drive(1, 8'h01, 1, 0);
        drive(1, 8'h01, 1, 0);
        chk("lit_rst_ready", int'(din_ready), 0);
        chk("lit_rst_count", int'(count), 0);
        chk("lit_rst_valid", int'(dout_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        chk("lit_ready_after_release", int'(din_ready), 1);

        // 2: walking one-hot stream with consumer always ready
        for (int i = 0; i < 8; i++) drive(1, 8'(1 << i), 1, 1);
        repeat (3) drive(1, 8'h00, 0, 1);
        chk("lit_count8", int'(count), 8);
        chk("lit_count_w2_sat", int'(count2), 3);
        chk("lit_last_idx7", int'(dout_idx), 7);

        // 3: zero and multi-hot samples
        drive(1, 8'h00, 1, 0);
        drive(1, 8'h0C, 1, 0);
        drive(1, 8'h00, 0, 0);
`ifdef EXAM_COLLECT_STRICT_EN
        chk("lit_strict_empty", int'(dout_valid), 0);
`else
        chk("lit_zero_head", int'(dout_zero), 1);
`endif
        repeat (3) drive(1, 8'h00, 0, 1);
        chk("lit_count_unchanged", int'(count), 8);
`ifdef EXAM_COLLECT_STRICT_EN
        chk("lit_multi_idx", int'(dout_idx), 7);
`else
        chk("lit_multi_idx", int'(dout_idx), 2);
        chk("lit_multi_onehot", int'(dout_onehot), 0);
`endif

        // 4: overfill with consumer stalled, then drain
        drive(1, 8'h01, 1, 0);
        drive(1, 8'h02, 1, 0);
        drive(1, 8'h04, 1, 0);
        drive(1, 8'h08, 1, 0);
        drive(1, 8'h10, 1, 0);
        drive(1, 8'h00, 0, 0);
        chk("lit_full_ready", int'(din_ready), 0);
        chk("lit_overflow", int'(overflow), 1);
        chk("lit_full_head", int'(dout_idx), 0);
        chk("lit_count12", int'(count), 12);
        repeat (5) drive(1, 8'h00, 0, 1);
        chk("lit_drain_idx", int'(dout_idx), 3);

        // 5: level 2, then simultaneous push/pop, then mid-stream reset
        drive(1, 8'h20, 1, 0);
        drive(1, 8'h40, 1, 0);
        for (int i = 0; i < 6; i++) drive(1, 8'(1 << (i % 8)), 1, 1);
        drive(1, 8'h80, 1, 1);
        chk("lit_steady_valid", int'(dout_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("lit_midrst_valid", int'(dout_valid), 0);
        chk("lit_midrst_count", int'(count), 0);
        chk("lit_midrst_ovf", int'(overflow), 0);
        drive(1, 8'h00, 0, 0);
        rst_n = 1'b1;

        // 6: fill, then offer with en low on a full FIFO, drain with en low
        drive(1, 8'h02, 1, 0);
        drive(1, 8'h04, 1, 0);
        drive(1, 8'h08, 1, 0);
        drive(1, 8'h10, 1, 0);
        repeat (3) drive(0, 8'h20, 1, 0);
        chk("lit_en0_ovf", int'(overflow), 0);
        chk("lit_en0_ready", int'(din_ready), 0);
        repeat (5) drive(0, 8'h20, 1, 1);
        chk("lit_en0_drained", int'(dout_valid), 0);
        chk("lit_en0_idx", int'(dout_idx), 4);
        drive(0, 8'h00, 0, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
